mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter DW, default 16, data width of the shared memory/IO port.
REQ-002 Parameter AW, default 13, address width of the shared memory/IO port.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req / m1_req  input  1  requester n wants one access this cycle.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  AW  access address.
REQ-008 m0_wdata / m1_wdata  input  DW  write data.
REQ-009 m0_lock / m1_lock  input  1  keep ownership after the current grant.
REQ-010 m0_gnt / m1_gnt  output  1  access accepted this cycle (combinational).
REQ-011 m0_rvalid / m1_rvalid  output  1  read data valid this cycle.
REQ-012 m0_rdata / m1_rdata  output  DW  read data; both driven from mem_dout.
REQ-013 mem_addr  output  AW, mem_din  output  DW, mem_we  output  1  shared port drive.
REQ-014 mem_dout  input  DW  shared port data; valid the cycle after a read address is presented with mem_we=0.

Function
REQ-015 At most one of m0_gnt, m1_gnt SHALL be 1 in any cycle; gnt SHALL only be asserted with the matching req.
REQ-016 The granted requester's we/addr/wdata SHALL drive mem_we/mem_addr/mem_din combinationally in the grant cycle; with no grant, mem_we SHALL be 0 and mem_addr/mem_din SHALL hold the last granted values.
REQ-017 Each grant SHALL perform exactly one access; back-to-back grants every cycle SHALL be supported.
REQ-018 A granted read SHALL raise that requester's rvalid exactly one cycle after the grant, for one cycle; a registered tag (valid + id) SHALL select which rvalid fires.
REQ-019 A granted write SHALL produce no rvalid.
REQ-020 FSM states: IDLE, OWN0, OWN1. IDLE: arbitrate per REQ-024/025. Grant to n with m_n_lock=1 -> OWNn. OWNn: only requester n may be granted; leave to IDLE in the first cycle m_n_lock=0 (that cycle may still grant n, arbitration resumes next cycle).
REQ-021 In OWNn with m_n_req=0 and lock=1, no grant SHALL be issued and state SHALL be held.
REQ-022 Simultaneous requests from both masters in IDLE SHALL be resolved in one cycle, with no idle bubble.
REQ-023 Read-response tag SHALL not be affected by a write granted in the following cycle (port keeps read address latched during writes).

Configuration
REQ-024 With macro MEM_ARB_RR_EN defined: round-robin; a 1-bit last-grant pointer updates on every grant; on contention, the requester not granted last wins; pointer resets to 1 (m0 wins first contention).
REQ-025 Without MEM_ARB_RR_EN: fixed priority, m0 always wins contention; no pointer register.

Reset
REQ-026 While rst=1: FSM=IDLE, tag valid=0, m0_rvalid=m1_rvalid=0, pointer=1, held mem_addr=0, mem_din=0, mem_we=0; gnt outputs 0 regardless of req.
REQ-027 A read granted in the cycle before rst asserts SHALL not produce rvalid after reset release; lock ownership SHALL be dropped.

Verification
REQ-028 m0 read addr 0x005 (memory holds 0x1234) -> m0_gnt=1 cycle T, m0_rvalid=1 with m0_rdata=0x1234 at T+1, m1_rvalid=0.
REQ-029 Both req reads for 4 cycles, RR_EN defined -> grants m0,m1,m0,m1; without -> m0 x4, m1 never.
REQ-030 m1 write 0x101 data 0xA5A5 with m1_lock=1 for 3 cycles, m0_req=1 throughout -> m0_gnt=0 until the cycle after m1_lock drops, then m0 granted.
REQ-031 m0 read 0x100 at T, m1 write 0x010 at T+1 -> m0_rvalid at T+1 returns the 0x100 data, no m1_rvalid.
REQ-032 rst pulsed at T+1 after read grant at T, while in OWN0 -> no rvalid, FSM IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb -- two-master arbiter for a single shared memory/IO port.
//
// Purpose:
//   Grants at most one of two requesters per cycle onto a shared single-port
//   memory interface. A granted requester may hold ownership across cycles via
//   its lock input. Read data returns one cycle after the grant, and a
//   registered tag steers rvalid to the requester that issued the read.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                  undefined -> fixed priority, m0 wins contention
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m{0,1}_req/we/addr/wdata requester access (write when we=1)
//   m{0,1}_lock              keep ownership after the current grant
//   m{0,1}_gnt               access accepted this cycle (combinational)
//   m{0,1}_rvalid/rdata      read response, one cycle after a read grant
//   mem_addr/mem_din/mem_we  shared port drive
//   mem_dout                 shared port read data (one cycle read latency)
module mem_arb #(
   parameter int DW = 16,
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_we,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state;
   logic          tag_vld;   // a read was granted last cycle
   logic          tag_id;    // which requester issued it (1 = m1)
   logic [AW-1:0] addr_q;    // last granted address, held when idle
   logic [DW-1:0] din_q;     // last granted write data, held when idle
   logic          gnt_any;
   logic          sel_we;

`ifdef MEM_ARB_RR_EN
   // Last-grant pointer: 1 means m1 was granted last, so m0 wins next tie.
   logic          ptr;
`endif

   // Grant decode. Ownership restricts the grant to the owner; in IDLE a tie
   // is resolved in the same cycle so back-to-back contention has no bubble.
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!rst) begin
         case (state)
            OWN0:    m0_gnt = m0_req;
            OWN1:    m1_gnt = m1_req;
            default: begin
               if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
                  m0_gnt = ptr;
                  m1_gnt = ~ptr;
`else
                  m0_gnt = 1'b1;
`endif
               end else begin
                  m0_gnt = m0_req;
                  m1_gnt = m1_req;
               end
            end
         endcase
      end
   end

   assign gnt_any = m0_gnt | m1_gnt;
   assign sel_we  = m1_gnt ? m1_we : m0_we;

   // Shared port: follow the granted requester, otherwise hold the last access
   // so a pending read address is not disturbed by an idle cycle.
   assign mem_we   = gnt_any & sel_we;
   assign mem_addr = m1_gnt ? m1_addr  : (m0_gnt ? m0_addr  : addr_q);
   assign mem_din  = m1_gnt ? m1_wdata : (m0_gnt ? m0_wdata : din_q);

   // Read response is steered by the tag; data comes straight from the port.
   assign m0_rvalid = tag_vld & ~tag_id;
   assign m1_rvalid = tag_vld &  tag_id;
   assign m0_rdata  = mem_dout;
   assign m1_rdata  = mem_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tag_vld <= 1'b0;
         tag_id  <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
`ifdef MEM_ARB_RR_EN
         ptr     <= 1'b1;
`endif
      end else begin
         // A write grant clears the tag, so only reads produce rvalid.
         tag_vld <= gnt_any & ~sel_we;
         tag_id  <= m1_gnt;
         if (gnt_any) begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
`ifdef MEM_ARB_RR_EN
            ptr    <= m1_gnt;
`endif
         end
         case (state)
            OWN0:    if (!m0_lock) state <= IDLE;
            OWN1:    if (!m1_lock) state <= IDLE;
            default: begin
               if (m0_gnt && m0_lock)      state <= OWN0;
               else if (m1_gnt && m1_lock) state <= OWN1;
               else                        state <= IDLE;
            end
         endcase
      end
   end

endmodule
